// File: rtl/btn_pkg.sv
// Shared types and defaults for the board push-button blocks.
package btn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int N_BTN_DEF    = 4;
  localparam int TICK_DIV_DEF = 1048576;
  localparam int ID_W         = $clog2(N_BTN_DEF);

endpackage

// File: rtl/btn_tick_gen.sv
// Free-running divider producing a one-cycle sample enable every TICK_DIV clocks.
module btn_tick_gen #(
  parameter int TICK_DIV = btn_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces N buttons on a shared tick and hands each press out as one event,
// round-robin, over a valid/ready port.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN    = N_BTN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  localparam int ID_BITS = $clog2(N_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn,
  output logic [N_BTN-1:0]   level,
  output logic               ev_valid,
  output logic [ID_BITS-1:0] ev_id,
  input  logic               ev_ready,
  output logic               overflow
);

  // Handshake: an event transfers on a posedge where ev_valid & ev_ready; once
  // raised, ev_valid and ev_id hold until that transfer (reset excepted).

  logic               tick;
  logic [N_BTN-1:0]   sync1, sync2, s1, s2;
  logic [N_BTN-1:0]   level_next, rise, clr, pending, pending_next;
  logic [ID_BITS-1:0] last_id, winner;
  logic               load, ovf_next;
  state_t             state, state_next;

  btn_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Level is the AND of the two newest samples: two highs to press, one low to release.
  assign level_next = tick ? (sync2 & s1) : level;
  assign rise       = level_next & ~level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      s1    <= '0;
      s2    <= '0;
      level <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (tick) begin
        s1 <= sync2;
        s2 <= s1;
      end
      level <= level_next;
    end
  end

  always_comb begin
    int idx;
    logic found;
    winner = last_id;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(last_id) + k) % N_BTN;
      if (!found && pending[idx]) begin
        winner = ID_BITS'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          load       = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          if (|pending) load = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise on the bit being loaded this cycle is a fresh event, not a merge.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr[i] = load && (winner == ID_BITS'(i));
    end
  end

  assign pending_next = (pending & ~clr) | rise;
  assign ovf_next     = |(rise & pending & ~clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      ev_id    <= '0;
      last_id  <= ID_BITS'(N_BTN - 1);
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      overflow <= ovf_next;
      if (load) begin
        ev_id   <= winner;
        last_id <= winner;
      end
    end
  end

  assign ev_valid = (state == OFFER);

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Shared-prescaler debouncer and event arbiter for the board push-buttons feeding the register-file lab controller. It samples N raw buttons on one common slow tick and debounces each. Each debounced press becomes a pending event. Pending events go out one at a time, round-robin, over a valid/ready handshake, so a single downstream sequencer consumes button commands without per-button debouncers or derived clocks.

## Interface
- N_BTN, 4: number of buttons, 2..8.
- TICK_DIV, 1048576: clk cycles per sample tick, ≥2 (benches use 4).
- clk  in  1  system clock; all logic on posedge, no derived clocks.
- rst_n  in  1  reset, synchronous, active-low.
- btn  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- level  out  N_BTN  debounced button levels.
- ev_valid  out  1  an event is offered.
- ev_id  out  $clog2(N_BTN)  index of the offered button.
- ev_ready  in  1  consumer accepts the event this cycle.
- overflow  out  1  one-cycle pulse when a press merges into an already-pending event.

## Operation
- Synchronizer: two clk flops per button (sync). Its output feeds the debouncer.
- Tick: counter cnt counts 0..TICK_DIV-1 and wraps to 0. tick = (cnt == TICK_DIV-1), a single-cycle enable, never used as a clock.
- Debounce: on tick, s2 <= s1 and s1 <= sync, per button.
  - level = s1 & s2 (registered).
  - Press needs two consecutive high samples; release needs one low sample.
- Edge: rise[i] = level_next[i] & ~level[i]. It is evaluated in the cycle the samples update.
- pending[N_BTN] register:
  - Set by rise.
  - Cleared when that index is loaded into the offer register.
  - If set and clear hit the same bit in the same cycle, set wins: a new press is a new event.
  - If rise[i] hits while pending[i]=1 and that bit is not cleared this cycle: the events merge and overflow pulses.
- Arbiter: round-robin over pending. Search starts at last_id+1 and wraps modulo N_BTN. last_id updates on every load.
- FSM:
  - IDLE: ev_valid=0. If pending≠0, load winner into ev_id and go to OFFER.
  - OFFER: ev_valid=1; ev_id is held stable while ev_ready=0.
  - OFFER with ev_ready=1: if pending≠0, load the next winner and stay in OFFER (back-to-back). Otherwise go to IDLE.
- A press of the button currently being offered re-pends it. The offered event itself is unaffected.

## Timing
- Reset values:
  - cnt=0, sync=s1=s2=0, level=0, pending=0.
  - State IDLE, ev_valid=0, ev_id=0, overflow=0.
  - last_id=N_BTN-1, so button 0 has first priority.
- Reset asserted mid-offer: the event is dropped and ev_valid=0 on the cycle after the reset edge. No partial state survives.
- Press latency, from a stable btn rise:
  - 2 cycles of sync.
  - Then up to two ticks: ≤2·TICK_DIV+2 cycles to the level rise.
  - pending is set in the same cycle as the level rise.
  - ev_valid=1 one cycle later if IDLE.
- Handshake: a transfer occurs on a posedge with ev_valid & ev_ready.
  - ev_valid never drops without a transfer, except on reset.
  - Throughput is 1 event/cycle when ready is held high.
- All outputs are registered. There is no combinational path from ev_ready to ev_valid or ev_id.

## Structure
- Shared package btn_pkg:
  - state enum {IDLE, OFFER}.
  - Default N_BTN and TICK_DIV constants.
  - ID_W = $clog2(N_BTN).
- Sub-module btn_tick_gen: parameter TICK_DIV; ports clk, rst_n, tick. It is reusable by other board-I/O blocks.
- Top: synchronizer, debounce shift pairs, pending register, rr arbiter and FSM inline. Target 150-250 lines of RTL.

## Test plan
- TICK_DIV=4, N_BTN=4, ev_ready=1. Hold btn=4'b0010 for 20 cycles.
  - level[1] rises once.
  - Exactly one handshake with ev_id=1, within 11 cycles of the btn edge.
- Bounce: btn[0] toggles every cycle for 12 cycles, then stays high.
  - level[0] goes high once only after two consecutive high ticks.
  - Exactly one event, id 0.
- ev_ready=0. Press buttons 3, 0 and 2 simultaneously.
  - ev_valid=1 with ev_id=0, held stable for 10 cycles.
  - Then raise ready: ids 0, 2, 3 on three consecutive cycles, then ev_valid=0.
- ev_ready=0, button 1 offered. Press button 2, release it, press it again before any handshake.
  - Second press gives overflow=1 for one cycle.
  - After ready: exactly ids 1, 2.
- Press button 1 to get ev_valid=1, then assert rst_n=0 for one cycle.
  - Next cycle: ev_valid=0, level=0, pending=0.
  - After release with btn still high, the event re-forms within 11 cycles.
